// File: rtl/sd_route_ctl.sv
// sd_route_ctl: SD SPI routing between host master, virtual cards and
// the physical slot, with image mount tracking, core reset and activity LEDs.
module sd_route_ctl #(
    parameter int NUM_IMG    = 2,
    parameter int IDX_W      = 2,
    parameter int ACT_CYCLES = 1000000,
    parameter int RST_CYCLES = 10000000
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [NUM_IMG-1:0] img_mounted,
    input  logic [NUM_IMG-1:0] img_size_nz,
    input  logic               sck,
    input  logic               mosi,
    input  logic               ss,
    output logic               miso,
    input  logic [NUM_IMG-1:0] vsd_miso,
    output logic [NUM_IMG-1:0] vsd_ss,
    input  logic               SD_MISO,
    output logic               SD_CS,
    output logic               SD_SCK,
    output logic               SD_MOSI,
    output logic               reset_img,
    output logic               sel_virt,
    output logic [IDX_W-1:0]   sel_idx,
    output logic               act_vsd,
    output logic               act_phy
);

    localparam int ACT_W = $clog2(ACT_CYCLES + 1);
    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam logic [ACT_W-1:0] ACT_MAX = ACT_W'(ACT_CYCLES);
    localparam logic [RST_W-1:0] RST_LD  = RST_W'(RST_CYCLES);

    logic [NUM_IMG-1:0] mounted_q, mounted_d;
    logic               pend_virt_q, pend_virt_d;
    logic [IDX_W-1:0]   pend_idx_q, pend_idx_d;
    logic               sel_virt_q, sel_virt_d;
    logic [IDX_W-1:0]   sel_idx_q, sel_idx_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [ACT_W-1:0]   vsd_tmr_q, vsd_tmr_d;
    logic [ACT_W-1:0]   phy_tmr_q, phy_tmr_d;
    logic               mosi_q, miso_q;

    logic               new_hit, fb_hit, pend_ej, act_tog, miso_v;
    logic [IDX_W-1:0]   new_idx, fb_idx;
    logic [NUM_IMG-1:0] vsd_ss_v;

    // Mount tracking and pending-target selection from this cycle's strobes
    always_comb begin
        mounted_d   = mounted_q;
        pend_virt_d = pend_virt_q;
        pend_idx_d  = pend_idx_q;
        new_hit     = 1'b0;
        new_idx     = '0;
        fb_hit      = 1'b0;
        fb_idx      = '0;
        pend_ej     = 1'b0;
        for (int i = 0; i < NUM_IMG; i++) begin
            if (img_mounted[i]) begin
                mounted_d[i] = img_size_nz[i];
                if (img_size_nz[i]) begin
                    new_hit = 1'b1;
                    new_idx = IDX_W'(i);
                end else if (pend_idx_q == IDX_W'(i)) begin
                    pend_ej = 1'b1;
                end
            end
        end
        for (int i = 0; i < NUM_IMG; i++) begin
            if (mounted_d[i]) begin
                fb_hit = 1'b1;
                fb_idx = IDX_W'(i);
            end
        end
        if (new_hit) begin
            pend_virt_d = 1'b1;
            pend_idx_d  = new_idx;
        end else if (pend_virt_q && pend_ej) begin
            pend_virt_d = fb_hit;
            pend_idx_d  = fb_hit ? fb_idx : '0;
        end
    end

    // Applied target, reset pulse counter and activity timers next state
    always_comb begin
        sel_virt_d = sel_virt_q;
        sel_idx_d  = sel_idx_q;
        rst_cnt_d  = rst_cnt_q;
        vsd_tmr_d  = vsd_tmr_q;
        phy_tmr_d  = phy_tmr_q;
        act_tog    = (mosi ^ mosi_q) | (miso_v ^ miso_q);
        if (ss) begin
            sel_virt_d = pend_virt_q;
            sel_idx_d  = pend_idx_q;
        end
        if (|img_mounted) begin
            rst_cnt_d = RST_LD;
        end else if (rst_cnt_q != '0) begin
            rst_cnt_d = rst_cnt_q - RST_W'(1);
        end
        if (act_tog && sel_virt_q) begin
            vsd_tmr_d = '0;
        end else if (vsd_tmr_q < ACT_MAX) begin
            vsd_tmr_d = vsd_tmr_q + ACT_W'(1);
        end
        if (act_tog && !sel_virt_q) begin
            phy_tmr_d = '0;
        end else if (phy_tmr_q < ACT_MAX) begin
            phy_tmr_d = phy_tmr_q + ACT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mounted_q   <= '0;
            pend_virt_q <= 1'b0;
            pend_idx_q  <= '0;
            sel_virt_q  <= 1'b0;
            sel_idx_q   <= '0;
            rst_cnt_q   <= '0;
            vsd_tmr_q   <= '0;
            phy_tmr_q   <= '0;
            mosi_q      <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            mounted_q   <= mounted_d;
            pend_virt_q <= pend_virt_d;
            pend_idx_q  <= pend_idx_d;
            sel_virt_q  <= sel_virt_d;
            sel_idx_q   <= sel_idx_d;
            rst_cnt_q   <= rst_cnt_d;
            vsd_tmr_q   <= vsd_tmr_d;
            phy_tmr_q   <= phy_tmr_d;
            mosi_q      <= mosi;
            miso_q      <= miso_v;
        end
    end

    // Combinational routing from the applied target
    always_comb begin
        miso_v   = SD_MISO;
        vsd_ss_v = '1;
        for (int k = 0; k < NUM_IMG; k++) begin
            if (sel_virt_q && sel_idx_q == IDX_W'(k)) begin
                miso_v      = vsd_miso[k];
                vsd_ss_v[k] = ss;
            end
        end
    end

    assign SD_CS     = sel_virt_q | ss;
    assign SD_SCK    = sck & ~SD_CS;
    assign SD_MOSI   = mosi & ~SD_CS;
    assign vsd_ss    = vsd_ss_v;
    assign miso      = miso_v;
    assign reset_img = rst_cnt_q != '0;
    assign sel_virt  = sel_virt_q;
    assign sel_idx   = sel_idx_q;
    assign act_vsd   = vsd_tmr_q < ACT_MAX;
    assign act_phy   = phy_tmr_q < ACT_MAX;

endmodule

// File: tb/tb_sd_route_ctl.sv
// tb_sd_route_ctl: directed stimulus for sd_route_ctl, checked every cycle
// against a cycle-count based model plus hand-computed expectations.
module tb_sd_route_ctl;

    localparam int NI  = 2;
    localparam int IW  = 2;
    localparam int ACT = 16;
    localparam int RST = 32;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic [NI-1:0] img_mounted = '0;
    logic [NI-1:0] img_size_nz = '0;
    logic          sck = 1'b0;
    logic          mosi = 1'b0;
    logic          ss = 1'b1;
    logic          miso;
    logic [NI-1:0] vsd_miso = '0;
    logic [NI-1:0] vsd_ss;
    logic          SD_MISO = 1'b0;
    logic          SD_CS, SD_SCK, SD_MOSI;
    logic          reset_img, sel_virt, act_vsd, act_phy;
    logic [IW-1:0] sel_idx;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    sd_route_ctl #(
        .NUM_IMG(NI), .IDX_W(IW), .ACT_CYCLES(ACT), .RST_CYCLES(RST)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .img_mounted(img_mounted), .img_size_nz(img_size_nz),
        .sck(sck), .mosi(mosi), .ss(ss), .miso(miso),
        .vsd_miso(vsd_miso), .vsd_ss(vsd_ss),
        .SD_MISO(SD_MISO), .SD_CS(SD_CS), .SD_SCK(SD_SCK), .SD_MOSI(SD_MOSI),
        .reset_img(reset_img), .sel_virt(sel_virt), .sel_idx(sel_idx),
        .act_vsd(act_vsd), .act_phy(act_phy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: slot state as ints (-1 = physical), times as cycle numbers
    int   cyc, rst_end, last_v, last_p, pend, appl, m_hi;
    bit   mnt[NI];
    logic pm_mosi, pm_miso, m_em;

    function automatic logic exp_miso();
        return (appl >= 0) ? vsd_miso[appl] : SD_MISO;
    endfunction

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cyc = 0; rst_end = -1; last_v = 0; last_p = 0;
            pend = -1; appl = -1; pm_mosi = 1'b0; pm_miso = 1'b0;
            for (int i = 0; i < NI; i++) mnt[i] = 1'b0;
        end else begin
            cyc++;
            m_em = exp_miso();
            if (mosi !== pm_mosi || m_em !== pm_miso) begin
                if (appl >= 0) last_v = cyc;
                else last_p = cyc;
            end
            pm_mosi = mosi;
            pm_miso = m_em;
            if (ss) appl = pend;
            if (img_mounted != 0) begin
                rst_end = cyc + RST - 1;
                m_hi = -1;
                for (int i = 0; i < NI; i++) begin
                    if (img_mounted[i]) mnt[i] = img_size_nz[i];
                    if (img_mounted[i] && img_size_nz[i]) m_hi = i;
                end
                if (m_hi >= 0) begin
                    pend = m_hi;
                end else if (pend >= 0 && img_mounted[pend] && !img_size_nz[pend]) begin
                    pend = -1;
                    for (int i = 0; i < NI; i++) if (mnt[i]) pend = i;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk_sys) begin
        if (chk_en) begin
            logic          e_cs;
            logic [NI-1:0] e_vss;
            e_cs = (appl >= 0) | ss;
            for (int k = 0; k < NI; k++) e_vss[k] = (appl != k) | ss;
            chk("sel_virt", sel_virt, appl >= 0);
            chk("sel_idx", sel_idx, (appl >= 0) ? appl : 0);
            chk("SD_CS", SD_CS, e_cs);
            chk("SD_SCK", SD_SCK, sck & ~e_cs);
            chk("SD_MOSI", SD_MOSI, mosi & ~e_cs);
            chk("vsd_ss", vsd_ss, e_vss);
            chk("miso", miso, exp_miso());
            chk("reset_img", reset_img, cyc <= rst_end);
            chk("act_vsd", act_vsd, (cyc - last_v) < ACT);
            chk("act_phy", act_phy, (cyc - last_p) < ACT);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Strobe m (non-zero), optional retrigger, count reset_img high cycles
    task automatic pulse_run(input int len, input int re_at,
                             input logic [NI-1:0] m, output int n);
        n = 0;
        img_mounted = m; img_size_nz = m;
        step(1);
        for (int j = 1; j <= len; j++) begin
            if (j == re_at) begin
                img_mounted = m; img_size_nz = m;
            end else begin
                img_mounted = '0; img_size_nz = '0;
            end
            @(negedge clk_sys);
            if (reset_img) n++;
            if (j == 2) begin
                chk("pulse_sel_virt", sel_virt, 1);
                chk("pulse_sel_idx", sel_idx, 1);
            end
            step(1);
        end
        img_mounted = '0; img_size_nz = '0;
    endtask

    initial begin
        int n, lv, hp;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1 chk_en = 1'b1;
        step(2);
        reset_n = 1'b1;

        // Idle after reset: physical path, indicators hold 16 cycles
        n = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk_sys);
            if (j == 0) begin
                chk("rst_sel_virt", sel_virt, 0);
                chk("rst_reset_img", reset_img, 0);
                chk("rst_SD_CS", SD_CS, 1);
                chk("rst_act_vsd", act_vsd, 1);
            end
            if (!act_phy) break;
            n++;
        end
        chk("idle_act_phy_len", n, 16);
        chk("idle_act_vsd_off", act_vsd, 0);
        step(1);

        // Mount slot 1, pulse length 32
        pulse_run(40, 0, 2'b10, n);
        chk("pulse_len", n, 32);
        ss = 1'b0;
        #1;
        chk("virt_SD_CS", SD_CS, 1);
        chk("virt_vsd_ss", vsd_ss, 2'b01);

        // Mount slot 0 while busy: applied frozen until ss rises
        img_mounted = 2'b01; img_size_nz = 2'b01;
        step(1);
        img_mounted = '0; img_size_nz = '0;
        step(3);
        chk("frozen_idx", sel_idx, 1);
        vsd_miso = 2'b10;
        #1 chk("frozen_miso", miso, 1);
        ss = 1'b1;
        step(1);
        chk("switch_idx", sel_idx, 0);
        vsd_miso = 2'b01;
        #1 chk("slot0_miso_hi", miso, 1);
        vsd_miso = 2'b10;
        #1 chk("slot0_miso_lo", miso, 0);
        vsd_miso = 2'b00;

        // Eject pending slot 0 -> slot 1, eject slot 1 -> physical
        step(1);
        img_mounted = 2'b01; img_size_nz = 2'b00;
        step(1);
        img_mounted = '0;
        step(1);
        chk("ej0_virt", sel_virt, 1);
        chk("ej0_idx", sel_idx, 1);
        img_mounted = 2'b10; img_size_nz = 2'b00;
        step(1);
        img_mounted = '0;
        step(1);
        chk("ej1_virt", sel_virt, 0);
        SD_MISO = 1'b1;
        #1 chk("phy_miso", miso, 1);
        ss = 1'b0;
        #1 chk("phy_SD_CS", SD_CS, 0);
        sck = 1'b1;
        #1 chk("phy_SD_SCK", SD_SCK, 1);
        sck = 1'b0;
        ss = 1'b1;

        // Mount both at once, retrigger at pulse cycle 20
        step(40);
        pulse_run(60, 20, 2'b11, n);
        chk("retrig_len", n, 52);

        // Periodic mosi toggles with slot 1 applied
        mosi = ~mosi;
        step(1);
        lv = 0; hp = 0;
        for (int j = 0; j < 60; j++) begin
            if (j % 10 == 9) mosi = ~mosi;
            @(negedge clk_sys);
            if (!act_vsd) lv++;
            if (act_phy) hp++;
            step(1);
        end
        chk("act_vsd_low_cycles", lv, 0);
        chk("act_phy_high_cycles", hp, 0);

        // Async reset in the middle of a reset pulse
        img_mounted = 2'b10; img_size_nz = 2'b10;
        step(1);
        img_mounted = '0; img_size_nz = '0;
        step(2);
        chk("pre_rst_reset_img", reset_img, 1);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_sel_virt", sel_virt, 0);
        chk("arst_sel_idx", sel_idx, 0);
        chk("arst_reset_img", reset_img, 0);
        chk("arst_act_vsd", act_vsd, 1);
        chk("arst_act_phy", act_phy, 1);
        chk("arst_SD_CS", SD_CS, 1);
        chk("arst_vsd_ss", vsd_ss, 2'b11);
        step(2);
        reset_n = 1'b1;
        step(5);
        chk("post_rst_sel_virt", sel_virt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_route_ctl.md
# sd_route_ctl

SPI routing and image-management block between the core's SD SPI master and up to NUM_IMG virtual SD card models plus the physical SD slot. It tracks per-slot image mount state, chooses the active target, and switches targets only while the bus is idle. It also generates the post-mount core reset pulse and drives per-path activity indicators for the LEDs. It sits in the emu top level between hps_io/sd_card instances and the core's SD_* pins.

## Interface
- NUM_IMG, 2 — number of virtual image slots, 1..4
- IDX_W, 2 — width of slot index, ≥ clog2(NUM_IMG), min 1
- ACT_CYCLES, 1000000 — activity hold time in clk_sys cycles
- RST_CYCLES, 10000000 — reset_img pulse length in clk_sys cycles

- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- img_mounted  in  NUM_IMG  per-slot one-cycle mount strobe
- img_size_nz  in  NUM_IMG  per-slot "image size non-zero", valid with the strobe
- sck, mosi  in  1  host SPI clock and data out
- ss  in  1  host chip select, active low
- miso  out  1  routed data back to host
- vsd_miso  in  NUM_IMG  MISO from each virtual card
- vsd_ss  out  NUM_IMG  per-virtual-card select, active low
- SD_MISO  in  1  physical card MISO
- SD_CS, SD_SCK, SD_MOSI  out  1  physical card pins
- reset_img  out  1  core cold-reset request after mount events
- sel_virt  out  1  1 = applied target is a virtual slot
- sel_idx  out  IDX_W  applied virtual slot index
- act_vsd, act_phy  out  1  activity indicators per path

## Operation
- Reset values: mounted = 0, pending and applied target = physical (sel_virt 0, sel_idx 0), reset_img 0, rst counter 0, both activity timers 0 (so act_vsd/act_phy start asserted and hold ACT_CYCLES cycles), edge-detect history 0.
- Mount event on slot i: mounted[i] <= img_size_nz[i].
- Pending target update on any strobe cycle:
  - Non-zero mount on slot i selects slot i; multiple simultaneous non-zero mounts: highest index wins.
  - Zero-size mount (eject) on the pending slot: fall back to highest-index slot still mounted after the update, else physical.
  - Eject of a non-pending slot: pending unchanged.
- Applied target <= pending only on a cycle where ss = 1 (bus idle). While ss = 0 the applied target is frozen; a transaction is never split across targets.
- Routing (combinational from applied target):
  - SD_CS = sel_virt | ss; SD_SCK = sck & ~SD_CS; SD_MOSI = mosi & ~SD_CS.
  - vsd_ss[k] = ~(sel_virt & sel_idx == k) | ss.
  - miso = sel_virt ? vsd_miso[sel_idx] : SD_MISO.
- reset_img: any mount strobe (zero or non-zero) loads rst counter with RST_CYCLES and sets reset_img next cycle; counter decrements to 0, reset_img clears on the cycle the counter reads 0. Retrigger during pulse reloads (pulse extends).
- Activity: registered mosi and miso; any toggle of either clears the timer of the path given by the applied target; each timer increments while < ACT_CYCLES and saturates. act_x = timer_x < ACT_CYCLES.

## Timing
- Mount strobe at cycle T: mounted/pending valid T+1; reset_img high T+1 through T+RST_CYCLES inclusive.
- Applied target follows pending on the first cycle with ss = 1 after pending changes; visible on outputs the following cycle (1-cycle register).
- Routing outputs: zero latency from sck/mosi/ss/miso inputs.
- Activity: toggle at cycle T -> timer 0 at T+1 -> act stays high through T+ACT_CYCLES.
- Async reset mid-operation: all state to reset values immediately; routing reverts to physical.

## Test plan
- ACT_CYCLES=16, RST_CYCLES=32, NUM_IMG=2. Reset release, no stimulus -> sel_virt 0, SD_CS = ss, act_phy and act_vsd high 16 cycles then low, reset_img 0.
- Pulse img_mounted=2'b10, size_nz=2'b10 with ss=1 -> sel_virt 1, sel_idx 1 within 2 cycles; reset_img high exactly 32 cycles; SD_CS 1, vsd_ss=2'b01 when ss=0.
- Hold ss=0, mount slot 0 non-zero -> applied stays slot 1 until ss goes 1, then slot 0 next cycle; miso follows vsd_miso[0].
- Both slots mounted, eject slot 0 (pending) -> fall back to slot 1; eject slot 1 -> physical, miso = SD_MISO.
- Mount both slots in same cycle -> slot 1 selected; second strobe at pulse cycle 20 -> reset_img total 52 cycles.
- Toggle mosi every 10 cycles with virtual selected -> act_vsd constantly high, act_phy low after initial 16; assert reset_n low mid-run -> all outputs to reset values asynchronously.
